// File: rtl/top_receiver.sv
// top_receiver: 8N1 UART receiver with mid-bit sampling, byte counter and start/num_bytes session tracking.
module top_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        system_clock,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        start,
  input  logic [14:0] num_bytes_to_receive,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_error,
  output logic [15:0] data_counter,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_error_q, frame_error_d;
  logic [15:0] data_counter_q, data_counter_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [14:0] target_q, target_d;
  logic        good, ferr, hit;
  logic [15:0] cnt_inc;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    good      = 1'b0;
    ferr      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : START;
      end
      START: if (cnt_q == CW'(HALF_BIT - 1)) begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        state_d   = rx_s_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
        cnt_d     = '0;
        shift_d   = {rx_s_q, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        state_d   = (bit_idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
        cnt_d   = '0;
        good    = rx_s_q;
        ferr    = ~rx_s_q;
        state_d = rx_s_q ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_d   = '0;
        state_d = rx_s_q ? IDLE : WAIT_HIGH;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  // A start pulse takes priority over a byte completing in the same cycle.
  always_comb begin
    cnt_inc        = data_counter_q + 16'd1;
    hit            = busy_q & good & (cnt_inc == {1'b0, target_q});
    rx_data_d      = good ? shift_q : rx_data_q;
    rx_valid_d     = good;
    frame_error_d  = ferr;
    target_d       = start ? num_bytes_to_receive : target_q;
    data_counter_d = start ? 16'd0 : good ? cnt_inc : data_counter_q;
    busy_d         = start ? (num_bytes_to_receive != 15'd0) : hit ? 1'b0 : busy_q;
    done_d         = ~start & hit;
  end
  always_ff @(posedge system_clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      data_counter_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      target_q       <= '0;
    end else begin
      rx_meta_q      <= rx;
      rx_s_q         <= rx_meta_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_error_q  <= frame_error_d;
      data_counter_q <= data_counter_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      target_q       <= target_d;
    end
  end
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_error  = frame_error_q;
  assign data_counter = data_counter_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_top_receiver.sv
// tb_top_receiver: scoreboard bench driving 8N1 frames at 16 clocks per bit.
module tb_top_receiver;
  localparam int CPB = 16;
  logic        system_clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic [14:0] num = '0;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_error, busy, done;
  logic [15:0] data_counter;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        fe;
    logic [7:0]  d;
    logic [15:0] c;
    logic        dn;
    logic        b;
  } exp_t;
  exp_t q[$];
  exp_t e;
  top_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .system_clock(system_clock), .rst_n(rst_n), .rx(rx), .start(start),
    .num_bytes_to_receive(num), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_error(frame_error), .data_counter(data_counter), .busy(busy), .done(done)
  );
  always #5 system_clock = ~system_clock;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask
  task automatic expect_ev(input logic fe, input logic [7:0] d, input logic [15:0] c, input logic dn, input logic b);
    exp_t x;
    x.fe = fe; x.d = d; x.c = c; x.dn = dn; x.b = b;
    q.push_back(x);
  endtask
  // Entered and left on a falling clock edge; coll raises start on the stop-sample edge.
  task automatic send(input logic [7:0] b, input logic stop_v, input logic coll, input logic [14:0] coll_num);
    rx = 1'b0;
    repeat (CPB) @(negedge system_clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge system_clock);
    end
    rx = stop_v;
    if (coll) begin
      repeat (10) @(negedge system_clock);
      start = 1'b1;
      num = coll_num;
      @(negedge system_clock);
      start = 1'b0;
      repeat (5) @(negedge system_clock);
    end else
      repeat (CPB) @(negedge system_clock);
  endtask
  task automatic pulse_start(input logic [14:0] n);
    start = 1'b1;
    num = n;
    @(negedge system_clock);
    start = 1'b0;
  endtask
  always @(negedge system_clock) if (rst_n) begin
    if (rx_valid || frame_error) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe got valid=%0b ferr=%0b data=%0h expected no strobe", rx_valid, frame_error, rx_data);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", {30'd0, rx_valid, frame_error}, {30'd0, ~e.fe, e.fe});
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
        chk("data_counter", {16'd0, data_counter}, {16'd0, e.c});
        chk("done", {31'd0, done}, {31'd0, e.dn});
        chk("busy", {31'd0, busy}, {31'd0, e.b});
      end
    end else if (done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_without_valid got done=1 expected 0");
    end
  end
  initial begin
    #10_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge system_clock);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_error}, 32'd0);
    chk("rst_counter", {16'd0, data_counter}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge system_clock);
    expect_ev(0, 8'hA5, 16'd1, 0, 0); send(8'hA5, 1, 0, 0);
    expect_ev(0, 8'h00, 16'd2, 0, 0); send(8'h00, 1, 0, 0);
    expect_ev(0, 8'hFF, 16'd3, 0, 0); send(8'hFF, 1, 0, 0);
    expect_ev(0, 8'h81, 16'd4, 0, 0); send(8'h81, 1, 0, 0);
    rx = 1'b0;
    repeat (3) @(negedge system_clock);
    rx = 1'b1;
    repeat (40) @(negedge system_clock);
    chk("glitch_counter", {16'd0, data_counter}, 32'd4);
    pulse_start(15'd0);
    chk("start0_counter", {16'd0, data_counter}, 32'd0);
    chk("start0_busy", {31'd0, busy}, 32'd0);
    expect_ev(1, 8'h81, 16'd0, 0, 0); send(8'h3C, 0, 0, 0);
    repeat (40) @(negedge system_clock);
    rx = 1'b1;
    repeat (20) @(negedge system_clock);
    expect_ev(0, 8'h3C, 16'd1, 0, 0); send(8'h3C, 1, 0, 0);
    pulse_start(15'd3);
    chk("arm_busy", {31'd0, busy}, 32'd1);
    chk("arm_counter", {16'd0, data_counter}, 32'd0);
    expect_ev(0, 8'h11, 16'd1, 0, 1); send(8'h11, 1, 0, 0);
    expect_ev(0, 8'h22, 16'd2, 0, 1); send(8'h22, 1, 0, 0);
    expect_ev(0, 8'h33, 16'd3, 1, 0); send(8'h33, 1, 0, 0);
    repeat (5) @(negedge system_clock);
    chk("session_end_busy", {31'd0, busy}, 32'd0);
    pulse_start(15'd2);
    expect_ev(0, 8'h5A, 16'd1, 0, 1); send(8'h5A, 1, 0, 0);
    expect_ev(0, 8'h6B, 16'd0, 0, 1); send(8'h6B, 1, 1, 15'd5);
    expect_ev(0, 8'h7E, 16'd1, 0, 1); send(8'h7E, 1, 0, 0);
    repeat (5) @(negedge system_clock);
    rx = 1'b0;
    repeat (CPB) @(negedge system_clock);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge system_clock);
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("midrst_counter", {16'd0, data_counter}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, rx_valid | frame_error | done}, 32'd0);
    repeat (3) @(negedge system_clock);
    rst_n = 1'b1;
    repeat (200) @(negedge system_clock);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge system_clock);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
